// File: rtl/rb_window_streamer_pkg.sv
// Shared definitions for the row-buffer window streamer.
// Holds the parameter defaults, the width helper used for derived widths
// and the control FSM state encoding.
package rb_window_streamer_pkg;

    localparam int DEF_PIXEL_WIDTH = 8;
    localparam int DEF_K           = 3;
    localparam int DEF_IMG_W       = 64;
    localparam int DEF_IMG_H       = 64;

    // Bits needed to index v entries, never less than one so that degenerate
    // sizes (a single row buffer) still get a legal vector.
    function automatic int clog2_min1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

    localparam int DEF_RB_ADDR = clog2_min1(DEF_K - 1);
    localparam int DEF_COL_W   = clog2_min1(DEF_IMG_W);
    localparam int DEF_ROW_W   = clog2_min1(DEF_IMG_H);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/rb_window_streamer_rb_bank.sv
// rb_bank: SLOTS independent single-clock BRAMs of DEPTH x PIXEL_WIDTH.
// All slots share one address; a read (enabled by en) returns every slot's
// old contents (read-first) while a write (we) lands only in slot wr_sel.
// Ports:
//   clk      clock
//   en       read enable; rd_data holds when low
//   we       write enable
//   addr     common read/write address
//   wr_sel   slot receiving wr_data
//   wr_data  pixel to store
//   rd_data  flattened read bus, slot s at [s*PIXEL_WIDTH +: PIXEL_WIDTH]
module rb_bank #(
    parameter int PIXEL_WIDTH = 8,
    parameter int SLOTS       = 2,
    parameter int DEPTH       = 64,
    parameter int ADDR_W      = 6,
    parameter int SEL_W       = 1
) (
    input  logic                         clk,
    input  logic                         en,
    input  logic                         we,
    input  logic [ADDR_W-1:0]            addr,
    input  logic [SEL_W-1:0]             wr_sel,
    input  logic [PIXEL_WIDTH-1:0]       wr_data,
    output logic [SLOTS*PIXEL_WIDTH-1:0] rd_data
);

    for (genvar s = 0; s < SLOTS; s++) begin : g_slot
        logic [PIXEL_WIDTH-1:0] mem [DEPTH];
        logic [PIXEL_WIDTH-1:0] rd_q;

        // Non-blocking read and write in one process gives read-first
        // semantics on a same-address access.
        always_ff @(posedge clk) begin
            if (en) rd_q <= mem[addr];
            if (we && wr_sel == SEL_W'(s)) mem[addr] <= wr_data;
        end

        assign rd_data[s*PIXEL_WIDTH +: PIXEL_WIDTH] = rd_q;
    end

endmodule

// File: rtl/rb_window_streamer.sv
// rb_window_streamer: accepts a raster pixel stream, keeps K-1 previous rows
// in BRAM row buffers and emits one K-pixel vertical column per accepted
// pixel (oldest row in the low field, current pixel in the top field).
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   start, pad_mode      frame start pulse; pad_mode latched on start
//   in_valid/in_ready    input pixel handshake, in_pixel raster data
//   out_valid/out_ready  output column handshake
//   out_col              K stacked pixels, field 0 = oldest row
//   out_row, out_x       position of the newest pixel of the column
//   busy                 high while a frame is in progress
//   complete             one-cycle pulse at the end of a frame
module rb_window_streamer
    import rb_window_streamer_pkg::*;
#(
    parameter int PIXEL_WIDTH = DEF_PIXEL_WIDTH,
    parameter int K           = DEF_K,
    parameter int IMG_W       = DEF_IMG_W,
    parameter int IMG_H       = DEF_IMG_H,
    localparam int SLOTS      = K - 1,
    localparam int RB_ADDR    = clog2_min1(K - 1),
    localparam int COL_W      = clog2_min1(IMG_W),
    localparam int ROW_W      = clog2_min1(IMG_H)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     pad_mode,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [PIXEL_WIDTH-1:0]   in_pixel,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [K*PIXEL_WIDTH-1:0] out_col,
    output logic [ROW_W-1:0]         out_row,
    output logic [COL_W-1:0]         out_x,
    output logic                     busy,
    output logic                     complete
);

    if (K < 2)      begin : g_bad_k $error("rb_window_streamer: K must be >= 2"); end
    if (IMG_W < 2)  begin : g_bad_w $error("rb_window_streamer: IMG_W must be >= 2"); end
    if (IMG_H < K)  begin : g_bad_h $error("rb_window_streamer: IMG_H must be >= K"); end

    state_t                     state, state_nx;
    logic                       accept, last_px, col_last;
    logic                       pad_q;
    logic [ROW_W-1:0]           row, row_q;
    logic [COL_W-1:0]           col, col_q;
    logic [RB_ADDR-1:0]         wr_sel, sel_q;
    logic [PIXEL_WIDTH-1:0]     pix_q;
    logic [SLOTS*PIXEL_WIDTH-1:0] rd_data;
    logic [K*PIXEL_WIDTH-1:0]   col_mux;

    // Single output stage: a pixel may enter whenever the output register is
    // empty or is being drained this cycle.
    assign in_ready = (state == ST_ACTIVE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign col_last = (col == COL_W'(IMG_W - 1));
    assign last_px  = col_last && (row == ROW_W'(IMG_H - 1));
    assign busy     = (state != ST_IDLE);
    assign complete = (state == ST_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:   if (start) state_nx = ST_ACTIVE;
            ST_ACTIVE: if (accept && last_px) state_nx = ST_DRAIN;
            ST_DRAIN:  if (!out_valid || out_ready) state_nx = ST_DONE;
            ST_DONE:   state_nx = ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase
    end

    // Raster position and the slot that receives the current row. wr_sel
    // rotates once per row so the slot being overwritten always holds the
    // oldest buffered row; with a single slot it stays at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pad_q  <= 1'b0;
            row    <= '0;
            col    <= '0;
            wr_sel <= '0;
        end else if (state == ST_IDLE && start) begin
            pad_q  <= pad_mode;
            row    <= '0;
            col    <= '0;
            wr_sel <= '0;
        end else if (accept) begin
            if (col_last) begin
                col    <= '0;
                row    <= row + 1'b1;
                wr_sel <= (wr_sel == RB_ADDR'(SLOTS - 1)) ? '0 : wr_sel + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // Output register; the BRAM read data lines up with it one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            pix_q     <= '0;
            row_q     <= '0;
            col_q     <= '0;
            sel_q     <= '0;
        end else if (accept) begin
            out_valid <= pad_q || (int'(row) >= K - 1);
            pix_q     <= in_pixel;
            row_q     <= row;
            col_q     <= col;
            sel_q     <= wr_sel;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    rb_bank #(
        .PIXEL_WIDTH (PIXEL_WIDTH),
        .SLOTS       (SLOTS),
        .DEPTH       (IMG_W),
        .ADDR_W      (COL_W),
        .SEL_W       (RB_ADDR)
    ) u_bank (
        .clk     (clk),
        .en      (accept),
        .we      (accept),
        .addr    (col),
        .wr_sel  (wr_sel),
        .wr_data (in_pixel),
        .rd_data (rd_data)
    );

    // Steering: field i comes from slot (sel_q+i) mod SLOTS, oldest first.
    // Rows above the frame top are zeroed in pad mode. The column reads zero
    // whenever nothing is valid, which also covers the unwritten BRAMs.
    always_comb begin
        col_mux = '0;
        for (int i = 0; i < SLOTS; i++) begin
            int slot;
            slot = (int'(sel_q) + i) % SLOTS;
            if (!(pad_q && int'(row_q) < K - 1 - i))
                col_mux[i*PIXEL_WIDTH +: PIXEL_WIDTH] = rd_data[slot*PIXEL_WIDTH +: PIXEL_WIDTH];
        end
        col_mux[SLOTS*PIXEL_WIDTH +: PIXEL_WIDTH] = pix_q;
        if (!out_valid) col_mux = '0;
    end

    assign out_col = col_mux;
    assign out_row = row_q;
    assign out_x   = col_q;

endmodule

// File: tb/tb_rb_window_streamer.sv
// Randomised bench for rb_window_streamer (K=3, 4x4 frames) against a
// frame-level reference: every expected column is built directly from the
// stored image and the window/pad rules, in raster order.
module tb_rb_window_streamer;

    localparam int PW = 8;
    localparam int K  = 3;
    localparam int W  = 4;
    localparam int H  = 4;

    logic          clk = 1'b0;
    logic          rst, start, pad_mode, in_valid, in_ready;
    logic [PW-1:0] in_pixel;
    logic          out_valid, out_ready, busy, complete;
    logic [K*PW-1:0] out_col;
    logic [1:0]    out_row, out_x;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [K*PW-1:0] col;
        int              row;
        int              x;
    } exp_t;

    exp_t          expq[$];
    logic [PW-1:0] img [H][W];

    always #5 clk = ~clk;

    rb_window_streamer #(.PIXEL_WIDTH(PW), .K(K), .IMG_W(W), .IMG_H(H)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .pad_mode  (pad_mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pixel  (in_pixel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_col   (out_col),
        .out_row   (out_row),
        .out_x     (out_x),
        .busy      (busy),
        .complete  (complete)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic build_model(input bit pad);
        exp_t e;
        expq.delete();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                if (pad || r >= K - 1) begin
                    e.col = '0;
                    for (int i = 0; i < K - 1; i++)
                        if (r - (K - 1) + i >= 0) e.col[i*PW +: PW] = img[r-(K-1)+i][c];
                    e.col[(K-1)*PW +: PW] = img[r][c];
                    e.row = r;
                    e.x   = c;
                    expq.push_back(e);
                end
    endtask

    // Called at posedge+1; the start pulse goes out immediately.
    task automatic run_frame(input bit pad, input bit rc_pix, input int ready_pct,
                             input int stall_at, input int abort_at, input bit poke_start);
        int              pidx, n_out;
        bit              done, was_stall, first;
        logic [K*PW-1:0] hcol;
        logic [1:0]      hrow, hx;
        exp_t            e;

        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                img[r][c] = rc_pix ? PW'(r*16 + c) : PW'($urandom_range(0, 255));
        build_model(pad);

        start = 1'b1; pad_mode = pad; in_valid = 1'b0; out_ready = 1'b1;
        pidx = 0; n_out = 0; done = 0; was_stall = 0; first = 1;
        hcol = '0; hrow = '0; hx = '0;

        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(negedge clk);
            if (was_stall) begin
                check("stall_col", out_col, hcol);
                check("stall_row", out_row, hrow);
                check("stall_x", out_x, hx);
            end
            was_stall = out_valid && !out_ready;
            if (was_stall) begin
                hcol = out_col; hrow = out_row; hx = out_x;
                check("stall_in_ready", in_ready, 1'b0);
            end
            if (out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    check("extra_output", 1'b1, 1'b0);
                end else begin
                    e = expq.pop_front();
                    check("col", out_col, e.col);
                    check("row", out_row, e.row);
                    check("x", out_x, e.x);
                    if (rc_pix) begin
                        if (!pad && first) begin
                            check("first_np_pos", {out_row, out_x}, 4'b1000);
                            check("first_np_col", out_col, 24'h201000);
                        end
                        if (pad && e.row == 0 && e.x == 0) check("pad_r0c0", out_col, 24'h000000);
                        if (pad && e.row == 1 && e.x == 1) check("pad_r1c1", out_col, 24'h110100);
                        if (e.row == 3 && e.x == 3)        check("rot_r3c3", out_col, 24'h332313);
                    end
                    first = 0;
                    n_out++;
                end
            end
            if (in_valid && in_ready) pidx++;

            if (abort_at >= 0 && pidx >= abort_at) begin
                #2 rst = 1'b1;
                #1;
                check("abort_out_valid", out_valid, 1'b0);
                check("abort_out_col", out_col, '0);
                check("abort_busy", busy, 1'b0);
                check("abort_in_ready", in_ready, 1'b0);
                in_valid = 1'b0; start = 1'b0;
                for (int j = 0; j < 3; j++) begin
                    @(negedge clk);
                    check("abort_no_complete", complete, 1'b0);
                end
                @(posedge clk); #1 rst = 1'b0;
                return;
            end

            if (complete) begin
                done = 1;
                break;
            end

            @(posedge clk); #1;
            start     = poke_start && cyc == 5;
            pad_mode  = !pad;
            in_valid  = (pidx < H*W) && ($urandom_range(0, 99) < 80);
            in_pixel  = (pidx < H*W) ? img[pidx / W][pidx % W] : '0;
            out_ready = ($urandom_range(0, 99) < ready_pct) && !(cyc >= stall_at && cyc < stall_at + 3);
        end

        check("frame_done", done, 1'b1);
        check("out_count", n_out, pad ? H*W : W*(H-K+1));
        @(posedge clk); #1;
        check("idle_busy", busy, 1'b0);
        check("complete_single", complete, 1'b0);
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; pad_mode = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; in_pixel = '0;
        #12;
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_col", out_col, '0);
        check("rst_out_row", out_row, '0);
        check("rst_out_x", out_x, '0);
        check("rst_busy", busy, 1'b0);
        check("rst_complete", complete, 1'b0);
        @(posedge clk); #1 rst = 1'b0;

        run_frame(0, 1, 100, 1000, -1, 0);   // non-pad, full rate
        run_frame(1, 1, 100, 1000, -1, 0);   // back-to-back, pad mode
        run_frame(1, 1, 70, 8, -1, 1);       // backpressure, forced stall, ignored start
        run_frame(0, 0, 60, 6, -1, 0);       // random pixels
        run_frame(1, 0, 100, 1000, 2*W + 1, 0); // reset mid row 2
        run_frame(0, 1, 100, 1000, -1, 0);   // clean frame after reset
        run_frame(1, 0, 50, 3, -1, 1);
        run_frame(0, 0, 80, 10, -1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
